// File: rtl/filtr_out_ser.sv
// Output serializer for the notch filter: buffers filtered samples in a small
// FIFO and shifts each one out MSB-first on an sclk/sdata/fsync link.
module filtr_out_ser #(
  parameter int unsigned DATA_SIZE  = 25,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_SIZE-2:0]   data_in,
  input  logic                          data_valid,
  output logic                          sclk,
  output logic                          sdata,
  output logic                          fsync,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int unsigned W     = DATA_SIZE - 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV) + 1;
  localparam int unsigned BIT_W = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t             state;
  logic [W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [W-1:0]       shreg;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               pop;
  logic               push;

  // Head is taken whenever the serializer is idle and something is queued;
  // a full FIFO still accepts a sample in the cycle its head leaves.
  assign pop  = (state == S_IDLE) && (fifo_count != '0);
  assign push = data_valid && ((fifo_count != CNT_W'(FIFO_DEPTH)) || pop);

  // Sample storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= $unsigned(data_in);
    end
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (data_valid && !push) begin
        overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer: pop, load, W bits of low/high sclk phases, then a gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      fsync   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sclk  <= 1'b0;
          sdata <= 1'b0;
          fsync <= 1'b0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          div_cnt <= '0;
          bit_cnt <= BIT_W'(W - 1);
          sclk    <= 1'b0;
          sdata   <= shreg[W-1];
          fsync   <= 1'b1;
          shreg   <= {shreg[W-2:0], 1'b0};
          state   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt == '0) begin
              sclk  <= 1'b0;
              sdata <= 1'b0;
              fsync <= 1'b0;
              state <= S_GAP;
            end else begin
              // New bit is presented only at the start of a low phase.
              bit_cnt <= bit_cnt - BIT_W'(1);
              sclk    <= 1'b0;
              sdata   <= shreg[W-1];
              fsync   <= 1'b0;
              shreg   <= {shreg[W-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_GAP: begin
          if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filtr_out_ser.sv
// Bench for filtr_out_ser: two instances (CLK_DIV=4 and CLK_DIV=1) share one
// stimulus stream; each is compared every cycle against a frame-timing model.
module tb_filtr_out_ser;

  localparam int W     = 24;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [W-1:0] data_in;
  logic                data_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 50) begin
        $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        n_print++;
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int CD    = (g == 0) ? 4 : 1;
    localparam int FRAME = 2 + (W + 1) * 2 * CD;

    logic       sclk, sdata, fsync, busy, overflow;
    logic [2:0] fifo_count;

    filtr_out_ser #(
      .DATA_SIZE (W + 1),
      .FIFO_DEPTH(DEPTH),
      .CLK_DIV   (CD)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .data_valid(data_valid),
      .sclk      (sclk),
      .sdata     (sdata),
      .fsync     (fsync),
      .fifo_count(fifo_count),
      .overflow  (overflow),
      .busy      (busy)
    );

    // Model: queue of samples plus the cycle offset k inside the current frame
    // (k=0 is the cycle right after the pop edge).
    logic [W-1:0] mq[$];
    logic [W-1:0] cur    = '0;
    bit           active = 1'b0;
    int           k      = 0;
    bit           ovf    = 1'b0;

    initial forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        active = 1'b0;
        k      = 0;
        ovf    = 1'b0;
      end else begin
        if (!active && mq.size() != 0) begin
          cur    = mq.pop_front();
          active = 1'b1;
          k      = 0;
        end else if (active) begin
          k++;
          if (k == FRAME - 1) active = 1'b0;
        end
        if (data_valid) begin
          if (mq.size() < DEPTH) mq.push_back(data_in);
          else ovf = 1'b1;
        end
      end
    end

    function automatic logic [7:0] expected();
      logic s, d, f;
      int   j, b;
      s = 1'b0; d = 1'b0; f = 1'b0;
      if (active && k >= 1 && k <= 2 * W * CD) begin
        j = k - 1;
        b = j / (2 * CD);
        s = (j % (2 * CD)) >= CD;
        d = cur[W-1-b];
        f = (b == 0);
      end
      return {s, d, f, active, ovf, 3'(mq.size())};
    endfunction

    // Per-cycle comparison and fsync rise timestamps.
    int   fs_t[$];
    logic prev_fs = 1'b0;
    initial forever begin
      @(negedge clk);
      if (chk_en) begin
        check($sformatf("ch%0d cyc%0d {sclk,sdata,fsync,busy,ovf,cnt}", g, cyc),
              32'({sclk, sdata, fsync, busy, overflow, fifo_count}), 32'(expected()));
        if (fsync && !prev_fs) fs_t.push_back(cyc);
        prev_fs = fsync;
      end
    end

    // Receiver: samples sdata on each sclk rise, fsync marks the MSB.
    logic [W-1:0] sh = '0;
    int           nb = 0;
    int           rises = 0;
    logic [W-1:0] rx[$];
    initial forever begin
      @(posedge sclk);
      rises++;
      if (fsync) nb = 0;
      sh = {sh[W-2:0], sdata};
      nb++;
      if (nb == W) begin
        rx.push_back(sh);
        nb = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] v);
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = v;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(g_ch[0].busy == 1'b0 && g_ch[0].fifo_count == 3'd0 &&
                 g_ch[1].busy == 1'b0 && g_ch[1].fifo_count == 3'd0) && i < budget);
    check({name, " drained in budget"}, 32'(i < budget), 32'd1);
  endtask

  initial begin
    int            n, r0, w0, burst;
    logic [W-1:0]  word;

    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset ch0 outputs", 32'({g_ch[0].sclk, g_ch[0].sdata, g_ch[0].fsync, g_ch[0].busy,
                                    g_ch[0].overflow, g_ch[0].fifo_count}), 32'd0);
    check("reset ch1 outputs", 32'({g_ch[1].sclk, g_ch[1].sdata, g_ch[1].fsync, g_ch[1].busy,
                                    g_ch[1].overflow, g_ch[1].fifo_count}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single sample 0x800001 from idle: latency, bit count, frame length.
    r0 = g_ch[0].rises;
    w0 = g_ch[0].rx.size();
    data_valid = 1'b1;
    data_in    = 24'h800001;
    @(negedge clk);
    data_valid = 1'b0;
    check("t1 count after push", 32'(g_ch[0].fifo_count), 32'd1);
    check("t1 busy before pop", 32'(g_ch[0].busy), 32'd0);
    @(negedge clk);
    check("t1 busy after pop", 32'(g_ch[0].busy), 32'd1);
    check("t1 count after pop", 32'(g_ch[0].fifo_count), 32'd0);
    @(negedge clk);
    check("t1 msb {sclk,sdata,fsync}", 32'({g_ch[0].sclk, g_ch[0].sdata, g_ch[0].fsync}), 32'b011);
    n = 2;
    while (g_ch[0].busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t1 busy low cycles after strobe", 32'(n), 32'd202);
    check("t1 sclk rises", 32'(g_ch[0].rises - r0), 32'd24);
    word = (g_ch[0].rx.size() > w0) ? g_ch[0].rx[w0] : '0;
    check("t1 received word", 32'(word), 32'h800001);
    wait_idle(100, "t1");

    // All-ones sample.
    w0 = g_ch[0].rx.size();
    send(24'hFFFFFF);
    wait_idle(400, "t2");
    word = (g_ch[0].rx.size() > w0) ? g_ch[0].rx[w0] : '0;
    check("t2 received word", 32'(word), 32'hFFFFFF);

    // Burst of five strobes during a running frame: fifth is dropped.
    send(24'h123456);
    repeat (2) @(negedge clk);
    w0 = g_ch[0].rx.size();
    for (int i = 1; i <= 5; i++) begin
      data_valid = 1'b1;
      data_in    = 24'(i * 24'h111111);
      @(negedge clk);
    end
    data_valid = 1'b0;
    check("t3 count full", 32'(g_ch[0].fifo_count), 32'd4);
    check("t3 overflow", 32'(g_ch[0].overflow), 32'd1);
    wait_idle(5 * 202 + 100, "t3");
    check("t3 frames received", 32'(g_ch[0].rx.size() - w0), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      word = (g_ch[0].rx.size() > w0 + i) ? g_ch[0].rx[w0+i] : '0;
      check($sformatf("t3 word %0d", i), 32'(word), 32'(i * 24'h111111));
    end

    // Full FIFO, strobe in the pop cycle: accepted without overflow.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = 24'(24'h0A0000 + i);
    end
    @(negedge clk);
    data_valid = 1'b0;
    n = 0;
    while (g_ch[0].busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4 count before pop", 32'(g_ch[0].fifo_count), 32'd4);
    data_valid = 1'b1;
    data_in    = 24'hABCDEF;
    @(negedge clk);
    data_valid = 1'b0;
    check("t4 count after push+pop", 32'(g_ch[0].fifo_count), 32'd4);
    check("t4 no overflow", 32'(g_ch[0].overflow), 32'd0);
    wait_idle(6 * 202 + 100, "t4");

    // Reset around bit 10 aborts the frame.
    send(24'h5A5A5A);
    r0 = g_ch[0].rises;
    n  = 0;
    while ((g_ch[0].rises - r0) < 10 && n < 300) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5 ch0 outputs after reset", 32'({g_ch[0].sclk, g_ch[0].sdata, g_ch[0].fsync,
                                           g_ch[0].busy, g_ch[0].overflow, g_ch[0].fifo_count}), 32'd0);
    r0 = g_ch[0].rises;
    w0 = g_ch[1].rises;
    repeat (300) @(negedge clk);
    check("t5 ch0 silent after reset", 32'(g_ch[0].rises - r0), 32'd0);
    check("t5 ch1 silent after reset", 32'(g_ch[1].rises - w0), 32'd0);

    // Two queued samples: frames back to back.
    g_ch[0].fs_t.delete();
    g_ch[1].fs_t.delete();
    send(24'h00FF00);
    send(24'h3C3C3C);
    wait_idle(600, "t6");
    check("t6 ch1 fsync count", 32'(g_ch[1].fs_t.size()), 32'd2);
    check("t6 ch1 fsync spacing",
          32'((g_ch[1].fs_t.size() == 2) ? g_ch[1].fs_t[1] - g_ch[1].fs_t[0] : 0), 32'd52);
    check("t6 ch0 fsync spacing",
          32'((g_ch[0].fs_t.size() == 2) ? g_ch[0].fs_t[1] - g_ch[0].fs_t[0] : 0), 32'd202);

    // Random traffic with bursts and occasional resets.
    burst = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 1999) == 0);
      data_in = W'($urandom);
      if (burst > 0) begin
        data_valid = 1'b1;
        burst--;
      end else if ($urandom_range(0, 399) == 0) begin
        burst      = $urandom_range(1, 6);
        data_valid = 1'b1;
      end else begin
        data_valid = ($urandom_range(0, 149) == 0);
      end
    end
    @(negedge clk);
    reset      = 1'b0;
    data_valid = 1'b0;
    wait_idle(6 * 202 + 100, "random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
